// File: rtl/ahb_mem_slave_if.sv
// ahb_mem_slave_if
//   AHB-Lite bus bundle between a single master and the word memory slave.
//   Clock and reset are kept as plain ports on the modules that use it.
// Signals
//   HADDR   32  byte address (address phase)
//   HWDATA  32  write data (data phase)
//   HWRITE   1  1=write 0=read
//   HBURST   1  burst hint, carried but unused by the slave
//   HSIZE    3  transfer size, only word (3'b010) is legal
//   HTRANS   2  00 IDLE, 01 BUSY, 10 NONSEQ, 11 SEQ
//   HREADY   1  data phase completes / slave accepts a new address
//   HRESP    1  0=OKAY 1=ERROR
//   HRDATA  32  read data
// Modports
//   master  drives address/control/write data, receives the response
//   slave   receives address/control/write data, drives the response
interface ahb_mem_slave_if;
    logic [31:0] HADDR;
    logic [31:0] HWDATA;
    logic        HWRITE;
    logic        HBURST;
    logic [2:0]  HSIZE;
    logic [1:0]  HTRANS;
    logic        HREADY;
    logic        HRESP;
    logic [31:0] HRDATA;

    modport master (
        output HADDR, HWDATA, HWRITE, HBURST, HSIZE, HTRANS,
        input  HREADY, HRESP, HRDATA
    );

    modport slave (
        input  HADDR, HWDATA, HWRITE, HBURST, HSIZE, HTRANS,
        output HREADY, HRESP, HRDATA
    );
endinterface

// File: rtl/ahb_mem_slave.sv
// ahb_mem_slave
//   AHB-Lite single-slave word memory. The address phase is captured on a
//   rising edge where HREADY is high and HTRANS is NONSEQ/SEQ; the data phase
//   then completes after WAIT_STATES stall cycles (OKAY) or through the
//   two-cycle ERROR response for illegal size, alignment or range.
// Parameters
//   DEPTH        number of 32-bit words (power of 2, >= 2)
//   BASE_ADDR    byte address of word 0
//   WAIT_STATES  HREADY-low cycles inserted per OKAY data phase (0..15)
// Ports
//   HCLK    in   clock, all state on the rising edge
//   HRESTn  in   asynchronous active-low reset
//   bus     slave modport of ahb_mem_slave_if (HADDR/HWDATA/HWRITE/HBURST/
//           HSIZE/HTRANS in, HREADY/HRESP/HRDATA out)
module ahb_mem_slave #(
    parameter int          DEPTH       = 16,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter int          WAIT_STATES = 1
) (
    input  logic            HCLK,
    input  logic            HRESTn,
    ahb_mem_slave_if.slave  bus
);
    localparam int          IDXW     = $clog2(DEPTH);
    localparam logic [32:0] SPAN     = 33'(DEPTH) << 2;
    localparam logic [3:0]  CNT_LOAD = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT,
        S_LAST,
        S_ERR1,
        S_ERR2
    } state_t;

    state_t          state;
    state_t          state_nxt;
    logic [3:0]      cnt;
    logic [3:0]      cnt_nxt;
    logic [IDXW-1:0] idx;
    logic            wr;
    logic [31:0]     mem [DEPTH];
    logic [31:0]     offset;
    logic            legal;
    logic            ready;
    logic            sample;
    logic            unused_bits;

    // Range check is done on the offset from BASE_ADDR in 33 bits so the
    // top of the window cannot wrap back into range.
    assign offset = bus.HADDR - BASE_ADDR;
    assign legal  = (bus.HSIZE == 3'b010) && (bus.HADDR[1:0] == 2'b00) &&
                    (bus.HADDR >= BASE_ADDR) && ({1'b0, offset} < SPAN);

    // HREADY depends on state only, so address sampling has no comb loop.
    assign ready  = (state != S_WAIT) && (state != S_ERR1);
    assign sample = ready && bus.HTRANS[1];

    assign unused_bits = ^{bus.HBURST, bus.HTRANS[0], offset[31:IDXW+2], offset[1:0]};

    // Next-state logic: IDLE, LAST and ERR2 all accept a new address phase.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            S_IDLE, S_LAST, S_ERR2: begin
                state_nxt = S_IDLE;
                if (sample) begin
                    if (!legal) begin
                        state_nxt = S_ERR1;
                    end else if (WAIT_STATES > 0) begin
                        state_nxt = S_WAIT;
                        cnt_nxt   = CNT_LOAD;
                    end else begin
                        state_nxt = S_LAST;
                    end
                end
            end
            S_WAIT: begin
                if (cnt == 4'd0) begin
                    state_nxt = S_LAST;
                end else begin
                    cnt_nxt = cnt - 4'd1;
                end
            end
            S_ERR1:  state_nxt = S_ERR2;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge HCLK or negedge HRESTn) begin
        if (!HRESTn) begin
            state <= S_IDLE;
            cnt   <= 4'd0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // Word index and direction are only latched for legal transfers; an
    // errored transfer never reaches LAST, so it cannot touch memory.
    always_ff @(posedge HCLK or negedge HRESTn) begin
        if (!HRESTn) begin
            idx <= '0;
            wr  <= 1'b0;
        end else if (sample && legal) begin
            idx <= offset[IDXW+1:2];
            wr  <= bus.HWRITE;
        end
    end

    // Write commits at the end of LAST, so a read captured on the same edge
    // sees the new value in its own data phase.
    always_ff @(posedge HCLK or negedge HRESTn) begin
        if (!HRESTn) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (state == S_LAST && wr) begin
            mem[idx] <= bus.HWDATA;
        end
    end

    assign bus.HREADY = ready;
    assign bus.HRESP  = (state == S_ERR1) || (state == S_ERR2);
    assign bus.HRDATA = (state == S_LAST && !wr) ? mem[idx] : 32'h0;
endmodule
